// File: rtl/hov_pkg.sv
// Shared definitions for the Hovalaag CPU I/O ports: word width, UART framing
// and the transmit state encoding.
package hov_pkg;

    localparam int WORD_W          = 12;
    localparam int UART_FRAME_BITS = 10;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    // A word leaves as two bytes: the zero-padded high nibble first, then the low byte.
    function automatic logic [7:0] word_byte(input logic [WORD_W-1:0] w, input logic sel);
        return sel ? w[7:0] : {4'h0, w[WORD_W-1:8]};
    endfunction

endpackage

// File: rtl/out_port_tx_if.sv
// CPU-facing write port of out_port_tx: write strobe/data plus FIFO status.
interface out_port_tx_if #(
    parameter int DEPTH_LOG2 = 4
);
    import hov_pkg::*;

    logic                  data_write;
    logic [WORD_W-1:0]     data_in;
    logic                  full;
    logic [DEPTH_LOG2:0]   count;
    logic                  overflow;

    modport master (output data_write, data_in, input full, count, overflow);
    modport slave  (input data_write, data_in, output full, count, overflow);

endinterface

// File: rtl/tx_fifo.sv
// Dual-pointer word FIFO with occupancy count and a registered head read that
// doubles as the transmitter's hold register.
module tx_fifo
    import hov_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [WORD_W-1:0]     push_data,
    input  logic                  pop,
    output logic [WORD_W-1:0]     rd_data,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WORD_W-1:0]     mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;

    assign full = (count == (DEPTH_LOG2 + 1)'(DEPTH));

    // NOTE: storage has no reset; the pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_data <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                rd_data <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/out_port_tx.sv
// Hovalaag output port: buffers CPU result words and sends each one as two
// 8N1 UART bytes, high nibble first.
module out_port_tx
    import hov_pkg::*;
#(
    parameter int DEPTH_LOG2   = 4,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic         clk,
    input  logic         rst_n,
    out_port_tx_if.slave wr,
    output logic         busy,
    output logic         txd
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    tx_state_t          state, state_n;
    logic [BAUD_W-1:0]  baud, baud_n;
    logic [2:0]         bit_idx, bit_idx_n;
    logic               byte_sel, byte_sel_n;
    logic               txd_n;
    logic               baud_end;
    logic               push;
    logic               pop;
    logic [WORD_W-1:0]  hold;
    logic [7:0]         cur_byte_n;

    // Acceptance uses full as it stood before the edge; a same-cycle pop does not free a slot.
    assign push     = wr.data_write && !wr.full;
    assign baud_end = (baud == BAUD_W'(CLKS_PER_BIT - 1));
    assign busy     = (state != IDLE);

    tx_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (wr.data_in),
        .pop       (pop),
        .rd_data   (hold),
        .count     (wr.count),
        .full      (wr.full)
    );

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_n    = state;
        baud_n     = baud + 1'b1;
        bit_idx_n  = bit_idx;
        byte_sel_n = byte_sel;
        pop        = 1'b0;
        txd_n      = 1'b1;

        case (state)
            IDLE: begin
                baud_n = '0;
                if (wr.count != '0) begin
                    pop        = 1'b1;
                    byte_sel_n = 1'b0;
                    state_n    = START;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_n    = '0;
                    bit_idx_n = 3'd0;
                    state_n   = DATA;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_n = '0;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_n = '0;
                    if (!byte_sel) begin
                        byte_sel_n = 1'b1;
                        state_n    = START;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // txd is registered from the next-state view so the pin never glitches on decode.
        cur_byte_n = word_byte(hold, byte_sel_n);
        case (state_n)
            START:   txd_n = 1'b0;
            DATA:    txd_n = cur_byte_n[bit_idx_n];
            default: txd_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            baud        <= '0;
            bit_idx     <= '0;
            byte_sel    <= 1'b0;
            txd         <= 1'b1;
            wr.overflow <= 1'b0;
        end else begin
            state    <= state_n;
            baud     <= baud_n;
            bit_idx  <= bit_idx_n;
            byte_sel <= byte_sel_n;
            txd      <= txd_n;
            if (wr.data_write && wr.full) begin
                wr.overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_out_port_tx.sv
// Self-checking bench for out_port_tx: a UART receiver decodes txd and the
// recovered byte pairs are compared against a queue of accepted words.
module tb_out_port_tx;

    localparam int DEPTH_LOG2 = 4;
    localparam int CPB        = 4;
    localparam int PERIOD     = 10;

    logic clk = 1'b0;
    logic rst_n;
    logic busy;
    logic txd;

    int n_checks = 0;
    int n_err    = 0;
    int frame_err = 0;

    logic [7:0]  rx_q[$];
    time         start_q[$];
    logic [11:0] exp_q[$];

    out_port_tx_if #(.DEPTH_LOG2(DEPTH_LOG2)) wr_if ();

    out_port_tx #(
        .DEPTH_LOG2   (DEPTH_LOG2),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wr    (wr_if),
        .busy  (busy),
        .txd   (txd)
    );

    always #(PERIOD / 2) clk = ~clk;

    initial begin
        #(500_000);
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // UART receiver: sample mid-bit on falling clock edges.
    initial begin
        logic [7:0] b;
        time        st;
        forever begin
            @(negedge txd);
            st = $time;
            repeat (2) @(negedge clk);
            if (txd !== 1'b0) frame_err++;
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                b[i] = txd;
            end
            repeat (CPB) @(negedge clk);
            if (txd !== 1'b1) frame_err++;
            rx_q.push_back(b);
            start_q.push_back(st);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_word(input logic [11:0] w);
        wr_if.data_write = 1'b1;
        wr_if.data_in    = w;
        @(negedge clk);
        wr_if.data_write = 1'b0;
    endtask

    task automatic wait_bytes(input string tag, input int n, input int budget);
        int k = 0;
        while (rx_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, rx_q.size(), n);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while ((busy !== 1'b0 || wr_if.count !== '0) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("idle_reached", {busy, 27'd0, wr_if.count}, 32'd0);
    endtask

    // Pair received bytes up and compare against the words the model accepted.
    task automatic drain_check(input string tag);
        int n = 2 * exp_q.size();
        wait_bytes({tag, "_bytes"}, n, n * (10 * CPB + 2) + 200);
        while (exp_q.size() > 0) begin
            logic [11:0] w  = exp_q.pop_front();
            logic [7:0]  hi = 8'hxx;
            logic [7:0]  lo = 8'hxx;
            if (rx_q.size() > 0) hi = rx_q.pop_front();
            if (rx_q.size() > 0) lo = rx_q.pop_front();
            check({tag, "_word"}, {16'd0, hi, lo}, {16'd0, 4'h0, w});
        end
    endtask

    initial begin
        int sent;
        int lows;
        bit saw_full;
        logic [11:0] w;

        rst_n            = 1'b0;
        wr_if.data_write = 1'b0;
        wr_if.data_in    = '0;
        repeat (3) @(negedge clk);

        check("rst_txd",      txd,            1);
        check("rst_busy",     busy,           0);
        check("rst_count",    wr_if.count,    0);
        check("rst_full",     wr_if.full,     0);
        check("rst_overflow", wr_if.overflow, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single word 0xA5C: 80-cycle frame pair, busy drops the cycle after.
        exp_q.push_back(12'hA5C);
        write_word(12'hA5C);
        check("single_count_after_write", wr_if.count, 1);
        check("single_busy_before_pop",   busy,        0);
        @(negedge clk);
        check("single_count_after_pop", wr_if.count, 0);
        check("single_busy_rise",       busy,        1);
        check("single_txd_start",       txd,         0);
        repeat (20 * CPB - 1) @(negedge clk);
        check("single_busy_last", busy, 1);
        @(negedge clk);
        check("single_busy_drop", busy, 0);
        check("single_txd_idle",  txd,  1);
        drain_check("single");
        start_q.delete();

        // Burst of 16 on consecutive cycles; second write lands on the popping edge.
        wait_idle(200);
        for (int i = 1; i <= 16; i++) begin
            exp_q.push_back(12'(i));
            wr_if.data_write = 1'b1;
            wr_if.data_in    = 12'(i);
            @(negedge clk);
            if (i == 1) check("burst_count_first", wr_if.count, 1);
            if (i == 2) begin
                check("same_edge_count", wr_if.count, 1);
                check("same_edge_busy",  busy,        1);
            end
        end
        wr_if.data_write = 1'b0;
        check("burst_count_end", wr_if.count, 15);
        check("burst_full_end",  wr_if.full,  0);
        wait_bytes("burst_timing_bytes", 32, 32 * (10 * CPB + 2) + 200);
        for (int k = 0; k < 16 && start_q.size() >= 32; k++) begin
            check("burst_byte_gap", int'((start_q[2*k+1] - start_q[2*k]) / PERIOD), 10 * CPB);
            if (k < 15)
                check("burst_word_gap", int'((start_q[2*k+2] - start_q[2*k]) / PERIOD), 20 * CPB + 1);
        end
        drain_check("burst");
        start_q.delete();
        check("burst_overflow", wr_if.overflow, 0);

        // Fill to 16 behind an in-flight word, then overflow with 0xFFF.
        wait_idle(200);
        for (int i = 0; i < 17; i++) begin
            w = 12'h100 + 12'(i * 7);
            exp_q.push_back(w);
            write_word(w);
        end
        check("fill_count",    wr_if.count,    16);
        check("fill_full",     wr_if.full,     1);
        check("fill_busy",     busy,           1);
        check("fill_overflow", wr_if.overflow, 0);
        write_word(12'hFFF);
        check("ovf_overflow", wr_if.overflow, 1);
        check("ovf_count",    wr_if.count,    16);
        check("ovf_busy",     busy,           1);
        drain_check("ovf");
        start_q.delete();
        check("ovf_sticky", wr_if.overflow, 1);

        // Asynchronous reset during the data bits of the second byte.
        wait_idle(200);
        write_word(12'h3C7);
        write_word(12'h2B1);
        repeat (10 * CPB + 2 * CPB + 5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_txd",      txd,            1);
        check("midrst_busy",     busy,           0);
        check("midrst_count",    wr_if.count,    0);
        check("midrst_full",     wr_if.full,     0);
        check("midrst_overflow", wr_if.overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;
        lows  = 0;
        for (int i = 0; i < 25 * CPB; i++) begin
            @(negedge clk);
            if (txd !== 1'b1) lows++;
        end
        check("postrst_txd_lows", lows, 0);
        check("postrst_busy",     busy, 0);
        rx_q.delete();
        start_q.delete();
        exp_q.delete();

        // Pointer wrap: 40 random words, writing only when full is low.
        sent     = 0;
        saw_full = 1'b0;
        for (int c = 0; c < 20000 && sent < 40; c++) begin
            if (wr_if.full === 1'b1) saw_full = 1'b1;
            if (wr_if.full === 1'b0 && $urandom_range(0, 3) != 0) begin
                w = 12'($urandom);
                exp_q.push_back(w);
                wr_if.data_write = 1'b1;
                wr_if.data_in    = w;
                sent++;
            end else begin
                wr_if.data_write = 1'b0;
            end
            @(negedge clk);
        end
        wr_if.data_write = 1'b0;
        check("wrap_sent",      sent,     40);
        check("wrap_stall_seen", saw_full, 1);
        drain_check("wrap");
        check("wrap_overflow", wr_if.overflow, 0);
        check("frame_errors",  frame_err,      0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/out_port_tx.md
# out_port_tx

Output-side port of the Hovalaag CPU: the CPU pushes 12-bit result words into a small FIFO, and the block drains them over an 8N1 UART transmit line to the host. It is the producer-to-host counterpart of the input FIFO that feeds the CPU. Each word goes out as two bytes, high byte first: {4'h0, w[11:8]}, then w[7:0]. The block sits between the CPU output register write strobe and the board TX pin.

## Interface
- DEPTH_LOG2, 4: FIFO depth is 2**DEPTH_LOG2 words (16).
- CLKS_PER_BIT, 868: clock cycles per UART bit (100 MHz / 115200). Must be ≥ 2.

- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- data_write  in  1  CPU write strobe; one word per asserted cycle.
- data_in  in  12  word to enqueue.
- full  out  1  combinational; high when count == 2**DEPTH_LOG2.
- count  out  DEPTH_LOG2+1  words held in the FIFO. Excludes the word currently being transmitted.
- overflow  out  1  sticky; set when data_write is asserted while full. Cleared only by reset.
- busy  out  1  high while a word is being serialized (any state other than IDLE).
- txd  out  1  UART line; idle high.

## Operation
- Write rule:
  - At a clock edge with data_write=1 and full=0, data_in is stored at the write pointer, the write pointer increments (wraps mod depth), and count increments.
  - With full=1, the word is dropped, the pointer and count do not change, and overflow is set.
  - Acceptance is judged on full as sampled before the edge. A pop in the same cycle does not make room.
- Simultaneous push and pop in the same cycle: count is unchanged and both pointers advance.
- FSM states: IDLE, START, DATA, STOP. A 1-bit byte_sel and a 3-bit bit index qualify the states.
  - IDLE: txd=1. If count≠0 at the edge, pop the head word into a 12-bit hold register, set byte_sel=0, go to START.
  - START: txd=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: txd = current byte bit[index], LSB first, each bit held CLKS_PER_BIT cycles. After bit 7, go to STOP.
  - STOP: txd=1 for CLKS_PER_BIT cycles. Then:
    - if byte_sel=0, set byte_sel=1 and go to START with no gap;
    - otherwise go to IDLE.
- Current byte: {4'h0, hold[11:8]} when byte_sel=0, else hold[7:0].
- Baud counter counts 0..CLKS_PER_BIT-1 and reloads at 0 on every state or bit change.
- Reset at any time, including mid-frame:
  - txd=1, full=0, count=0, busy=0, overflow=0, FSM=IDLE;
  - both pointers 0; FIFO contents discarded. Storage array needs no reset.

## Timing
- A write into an empty, idle block: count=1 after edge N. At edge N+1, IDLE pops the word: count=0, txd falls, busy rises.
- One word occupies exactly 20×CLKS_PER_BIT cycles from txd falling to the end of the second stop bit.
- Streaming: after the final stop bit, FSM spends exactly 1 cycle in IDLE. The next start bit begins 20×CLKS_PER_BIT+1 cycles after the previous one.
- full, count and busy are registered-state derived and have no combinational path from data_write. overflow is updated at the same edge as the offending write.

## Structure
- Shared package hov_pkg holds:
  - WORD_W = 12;
  - the tx state enum (IDLE, START, DATA, STOP);
  - UART_FRAME_BITS = 10.
- One sub-module, tx_fifo: dual-pointer storage with count/full and push/pop strobes, plus registered head read.
- The UART FSM and baud counter live in out_port_tx.

## Test plan
- Single word, CLKS_PER_BIT=4, write 12'hA5C:
  - txd shows start, 0x0A LSB-first, stop, then start, 0x5C, stop;
  - total 80 cycles; busy drops on the cycle after.
- Burst of 16 writes (0x001..0x010) on consecutive cycles into an idle block:
  - first word popped at the cycle after the first write; after the burst, count=15, full=0;
  - all 16 words are transmitted in order, with 1-cycle IDLE gaps (81 cycles per word).
- Fill to 16 while a word is in flight (busy=1 throughout), then write 12'hFFF:
  - word dropped, overflow=1, count stays 16;
  - transmitted sequence omits 0xFFF.
- Pointer wrap: stream 40 words with occasional full stalls honoured by the bench:
  - received byte pairs reconstruct the 40 words exactly and in order.
- Reset mid-frame during DATA of byte 1:
  - txd=1 immediately (asynchronous), count=0, busy=0, overflow=0;
  - after release with no writes, txd stays high.
- Write on the same edge that IDLE pops the last entry:
  - count goes 1→1, and the new word is sent after the current one.
